// File: rtl/ika2151_pkg.sv
// Shared constants and types for the FM core DAC receive path.
package ika2151_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int MANT_W         = 10;
    localparam int EXP_W          = 3;
    localparam int FRAME_MIN_BITS = 13;

    typedef struct packed {
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } dac_float_t;

    // True when a latch would use fewer bits than a full float frame.
    function automatic logic frame_short(input logic [5:0] bits_seen);
        return (bits_seen < 6'(FRAME_MIN_BITS));
    endfunction

endpackage

// File: rtl/mdl_dacrx_decode.sv
// Float-to-linear conversion of one DAC frame: offset-binary mantissa scaled by 2^(exp-1).
module mdl_dacrx_decode
    import ika2151_pkg::*;
(
    input  dac_float_t                  flt,
    output logic signed [SAMPLE_W-1:0]  pcm
);

    logic signed [SAMPLE_W-1:0] base_s;

    // Flip the mantissa MSB to turn offset binary into two's complement, then scale.
    always_comb begin
        base_s = {{(SAMPLE_W-MANT_W+1){~flt.mant[MANT_W-1]}}, flt.mant[MANT_W-2:0]};
        if (flt.exp == 3'd0) begin
            pcm = 16'sd0;
        end else begin
            pcm = base_s <<< (flt.exp - 3'd1);
        end
    end

endmodule

// File: rtl/mdl_dacrx.sv
// Serial DAC receiver: deserialises SO on phi1 enables and latches per-channel samples on SH falls.
module mdl_dacrx
    import ika2151_pkg::*;
#(
    parameter bit MUTE_ON_ERR = 1'b0,
    parameter int SAT_CNT     = 31
)
(
    input  logic                 i_EMUCLK,
    input  logic                 i_RST,
    input  logic                 i_phi1_PCEN_n,
    input  logic                 i_SO,
    input  logic                 i_SH1,
    input  logic                 i_SH2,
    output logic [SAMPLE_W-1:0]  o_CH1,
    output logic [SAMPLE_W-1:0]  o_CH2,
    output logic                 o_CH1_VALID,
    output logic                 o_CH2_VALID,
    output logic                 o_FRAME_ERR
);

    logic [15:0]                sr_r;
    logic [15:0]                next_sr_s;
    logic [4:0]                 bitcnt_r;
    logic [5:0]                 bitcnt_inc_s;
    logic                       sh1_q_r;
    logic                       sh2_q_r;
    logic                       fall1_s;
    logic                       fall2_s;
    logic                       short_s;
    dac_float_t                 flt_s;
    logic signed [SAMPLE_W-1:0] pcm_s;
    logic signed [SAMPLE_W-1:0] latch_val_s;
    logic [SAMPLE_W-1:0]        ch1_r;
    logic [SAMPLE_W-1:0]        ch2_r;
    logic                       ch1_valid_r;
    logic                       ch2_valid_r;
    logic                       frame_err_r;

    // The captured frame includes the bit arriving in the latch cycle itself.
    always_comb begin
        next_sr_s    = {i_SO, sr_r[15:1]};
        bitcnt_inc_s = {1'b0, bitcnt_r} + 6'd1;
        fall1_s      = sh1_q_r & ~i_SH1;
        fall2_s      = sh2_q_r & ~i_SH2;
        short_s      = frame_short(bitcnt_inc_s);
        flt_s        = next_sr_s[15:3];
        if (MUTE_ON_ERR && short_s) begin
            latch_val_s = 16'sd0;
        end else begin
            latch_val_s = pcm_s;
        end
    end

    mdl_dacrx_decode u_decode (
        .flt (flt_s),
        .pcm (pcm_s)
    );

    // Shift, edge detect, bit counting and output latching, all gated by the phi1 enable.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            sr_r        <= 16'd0;
            bitcnt_r    <= 5'd0;
            sh1_q_r     <= 1'b0;
            sh2_q_r     <= 1'b0;
            ch1_r       <= 16'd0;
            ch2_r       <= 16'd0;
            ch1_valid_r <= 1'b0;
            ch2_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            ch1_valid_r <= 1'b0;
            ch2_valid_r <= 1'b0;
            if (!i_phi1_PCEN_n) begin
                sr_r    <= next_sr_s;
                sh1_q_r <= i_SH1;
                sh2_q_r <= i_SH2;
                if (fall1_s || fall2_s) begin
                    bitcnt_r <= 5'd0;
                    if (short_s) begin
                        frame_err_r <= 1'b1;
                    end
                end else if (bitcnt_inc_s >= 6'(SAT_CNT)) begin
                    bitcnt_r <= 5'(SAT_CNT);
                end else begin
                    bitcnt_r <= bitcnt_inc_s[4:0];
                end
                if (fall1_s) begin
                    ch1_r       <= latch_val_s;
                    ch1_valid_r <= 1'b1;
                end
                if (fall2_s) begin
                    ch2_r       <= latch_val_s;
                    ch2_valid_r <= 1'b1;
                end
            end
        end
    end

    assign o_CH1       = ch1_r;
    assign o_CH2       = ch2_r;
    assign o_CH1_VALID = ch1_valid_r;
    assign o_CH2_VALID = ch2_valid_r;
    assign o_FRAME_ERR = frame_err_r;

endmodule

// File: doc/mdl_dacrx.md
Name: mdl_dacrx

Overview:
- Receiving end of the FM core's serial DAC interface (SO/SH1/SH2, timed by phi1); the behavioural equivalent of the YM3012 input stage.
- Deserialises the floating-point sample stream and latches channel 1 on the falling edge of SH1 and channel 2 on the falling edge of SH2.
- Converts each 13-bit float (10-bit mantissa, 3-bit exponent) to signed 16-bit linear PCM.
- Used in the bench and as an optional top-level audio back end.

Parameters:
MUTE_ON_ERR, 0, 1 = a frame with fewer than 13 bits latches 0 instead of the decoded value
SAT_CNT, 31, saturation value of the bit counter (5-bit)

Ports:
i_EMUCLK  input  1  emulator master clock; the only clock
i_RST  input  1  asynchronous, active-high reset
i_phi1_PCEN_n  input  1  active-low enable, one EMUCLK cycle per phi1 rising edge; all sampling happens here
i_SO  input  1  serial data from the FM core
i_SH1  input  1  channel 1 sample-and-hold strobe
i_SH2  input  1  channel 2 sample-and-hold strobe
o_CH1  output  16  channel 1 linear sample, two's complement
o_CH2  output  16  channel 2 linear sample, two's complement
o_CH1_VALID  output  1  one-EMUCLK pulse when o_CH1 updates
o_CH2_VALID  output  1  one-EMUCLK pulse when o_CH2 updates
o_FRAME_ERR  output  1  sticky flag: a latch occurred with fewer than 13 bits received; cleared only by reset

Behaviour:
- Reset (async, i_RST=1):
  - sr=0, bitcnt=0, sh1_q=0, sh2_q=0.
  - o_CH1=o_CH2=0, both VALID=0, o_FRAME_ERR=0.
  - Reset mid-frame discards the partial frame; the first frame after release normally flags an error unless at least 13 bits arrive before the first latch.
- Sampling, only in cycles with i_phi1_PCEN_n=0; all other cycles hold state:
  - sr <= {i_SO, sr[15:1]}, i.e. LSB-first, newest bit in sr[15].
  - sh1_q <= i_SH1; sh2_q <= i_SH2.
  - bitcnt <= min(bitcnt+1, SAT_CNT).
- Latch events, evaluated in the same enable cycle:
  - fall1 = sh1_q & ~i_SH1; fall2 = sh2_q & ~i_SH2.
  - Frame captured = the register contents including the bit shifted in this cycle. That is the last 13 bits received: mantissa m[9:0] first (LSB-first), then exponent e[2:0] (LSB-first).
  - Therefore e = next_sr[15:13] and m = next_sr[12:3].
  - On any fall: bitcnt <= 0, not incremented.
  - If the pre-increment bitcnt+1 < 13, set o_FRAME_ERR.
- Decode (combinational):
  - s[9:0] = {~m[9], m[8:0]} as a signed 10-bit value, range -512..511.
  - If e=0, out = 0.
  - Otherwise out = sign_extend16(s) <<< (e-1), shift 0..6. No overflow is possible: the range is -32768..32704.
- Output register and latency:
  - o_CHx and o_CHx_VALID update on the EMUCLK edge that ends the enable cycle containing the fall.
  - VALID is high for exactly one EMUCLK cycle.
  - If MUTE_ON_ERR=1 and the frame is short, the output is 0; VALID still pulses.
- Simultaneous fall1 and fall2: both channels latch the same decoded value and both VALIDs pulse in the same cycle. The error check is applied once.
- SH high across multiple enables produces no extra events. Rising edges of SH are ignored.
- bitcnt saturates at SAT_CNT, so a long gap yields no wrap and no false error.
- No handshake: a consumer that misses a VALID pulse simply sees the held value.

Decomposition:
- Shared package (ika2151_pkg):
  - SAMPLE_W=16, MANT_W=10, EXP_W=3, FRAME_MIN_BITS=13.
  - typedef dac_float_t {exp[2:0], mant[9:0]}.
- Sub-module mdl_dacrx_decode: purely combinational float-to-linear, reused by the bench reference model.
- Shift register, edge detect, counter and output registers stay in mdl_dacrx.

Test Plan:
- Send 16 bits per frame, then drop SH1.
  - m=0x3FF, e=7 -> o_CH1=0x7FC0, o_CH1_VALID one pulse.
  - m=0x000, e=7 -> o_CH1=0x8000.
- m=0x2AB, e=3, latched on SH2 -> o_CH2=0x02AC; o_CH1 unchanged.
- Zero cases: m=0x200, e=1 -> 0x0000; m=0x3FF, e=0 -> 0x0000.
- Short frame:
  - Only 8 bits between SH falls -> o_FRAME_ERR=1 and stays 1.
  - With MUTE_ON_ERR=1 -> o_CH1=0.
- SH1 and SH2 fall in the same enable with m=0x3FF, e=7 -> both outputs 0x7FC0, both VALIDs in the same cycle.
- Reset during a frame:
  - Assert i_RST between phi1 enables -> all outputs 0 immediately.
  - After release, a 16-bit frame decodes correctly with no error.
  - Hold enables off for 100 EMUCLK -> no state change.
